// File: rtl/ternary_mem_arbiter_pkg.sv
// rtl/ternary_mem_arbiter_pkg.sv - shared sizes, trit encoding and arbiter state constants
// Purpose: common definitions for the ternary memory arbiter and its sub-module.
// Contents: WORD_SIZE / MEM_ADDR_SIZE in trits, default STARVE_LIMIT,
//           starvation counter width, zero-trit encoding, arbiter state enum.
package ternary_mem_arbiter_pkg;

  localparam int WORD_SIZE     = 9;
  localparam int MEM_ADDR_SIZE = 9;
  localparam int STARVE_LIMIT  = 4;

  // Wide enough for the largest allowed STARVE_LIMIT (15).
  localparam int STARVE_W = 4;

  // Two bits per trit; the zero trit is all-zero bits.
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ARB_IDLE       = 2'd0,
    ARB_CPU        = 2'd1,
    ARB_EXT        = 2'd2,
    ARB_EXT_LOCKED = 2'd3
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// rtl/arb_starve_counter.sv - saturating count of contested cycles lost by the external side
// Purpose: counts consecutive contested cycles the CPU won; clears on request.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   inc           a contested cycle was won by the CPU
//   clr           external side granted or not requesting
//   at_limit      count has reached LIMIT
module arb_starve_counter
  import ternary_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [STARVE_W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count < STARVE_W'(LIMIT))) begin
      count <= count + 1'b1;
    end
  end

  assign at_limit = (count >= STARVE_W'(LIMIT));

endmodule

// File: rtl/ternary_mem_arbiter.sv
// rtl/ternary_mem_arbiter.sv - shares one ternary memory port between the CPU and an external requester
// Purpose: fixed CPU priority with a starvation override and an external lock for bursts.
// Ports:
//   clock, reset                          clock, synchronous active-high reset
//   cpu_mem_read/_write/_address/_write_data  CPU request side
//   cpu_mem_read_data, cpu_wait           CPU response / stall
//   ext_req/_we/_lock/_address/_write_data    external request side
//   ext_ack, ext_read_data                external completion
//   mem_address/_write_data/_read/_write  memory request, mem_read_data response
//   owner                                 registered arbiter state
module ternary_mem_arbiter
  import ternary_mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE     = ternary_mem_arbiter_pkg::WORD_SIZE,
  parameter int MEM_ADDR_SIZE = ternary_mem_arbiter_pkg::MEM_ADDR_SIZE,
  parameter int STARVE_LIMIT  = ternary_mem_arbiter_pkg::STARVE_LIMIT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cpu_mem_read,
  input  logic                       cpu_mem_write,
  input  logic [2*MEM_ADDR_SIZE-1:0] cpu_mem_address,
  input  logic [2*WORD_SIZE-1:0]     cpu_mem_write_data,
  output logic [2*WORD_SIZE-1:0]     cpu_mem_read_data,
  output logic                       cpu_wait,
  input  logic                       ext_req,
  input  logic                       ext_we,
  input  logic                       ext_lock,
  input  logic [2*MEM_ADDR_SIZE-1:0] ext_address,
  input  logic [2*WORD_SIZE-1:0]     ext_write_data,
  output logic                       ext_ack,
  output logic [2*WORD_SIZE-1:0]     ext_read_data,
  output logic [2*MEM_ADDR_SIZE-1:0] mem_address,
  output logic [2*WORD_SIZE-1:0]     mem_write_data,
  output logic                       mem_read,
  output logic                       mem_write,
  input  logic [2*WORD_SIZE-1:0]     mem_read_data,
  output logic [1:0]                 owner
);

  arb_state_e              state;
  logic                    rd_owner;     // last granted read belonged to the CPU
  logic                    ext_ack_q;
  logic                    ext_rd_ack;   // this cycle acks an external read
  logic [2*WORD_SIZE-1:0]  ext_rd_hold;

  logic cpu_req;
  logic cpu_rd_eff;
  logic locked;
  logic at_limit;
  logic starve_hit;
  logic cpu_grant;
  logic ext_grant;

  assign cpu_req    = cpu_mem_read | cpu_mem_write;
  // A simultaneous read+write strobe is treated as a write.
  assign cpu_rd_eff = cpu_mem_read & ~cpu_mem_write;

  // During the reset cycle the grant decision behaves as if from IDLE with a
  // cleared starvation count, whatever the registered state still holds.
  assign locked     = (state == ARB_EXT_LOCKED) && !reset;
  assign starve_hit = at_limit && !reset;

  assign cpu_grant  = !locked && cpu_req && !starve_hit;
  assign ext_grant  = ext_req && !cpu_grant;
  assign cpu_wait   = cpu_req && !cpu_grant;

  arb_starve_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clock   (clock),
    .reset   (reset),
    .inc     (cpu_grant && ext_req),
    .clr     (ext_grant || !ext_req),
    .at_limit(at_limit)
  );

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = {MEM_ADDR_SIZE{TRIT_ZERO}};
    mem_write_data = {WORD_SIZE{TRIT_ZERO}};
    if (cpu_grant) begin
      mem_read       = cpu_rd_eff;
      mem_write      = cpu_mem_write;
      mem_address    = cpu_mem_address;
      mem_write_data = cpu_mem_write_data;
    end else if (ext_grant) begin
      mem_read       = !ext_we;
      mem_write      = ext_we;
      mem_address    = ext_address;
      mem_write_data = ext_write_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rd_owner    <= 1'b0;
      ext_ack_q   <= 1'b0;
      ext_rd_ack  <= 1'b0;
      ext_rd_hold <= '0;
    end else begin
      rd_owner   <= cpu_grant && cpu_rd_eff;
      ext_ack_q  <= ext_grant;
      ext_rd_ack <= ext_grant && !ext_we;
      if (ext_rd_ack) begin
        ext_rd_hold <= mem_read_data;
      end
      if (cpu_grant) begin
        state <= ARB_CPU;
      end else if (ext_grant) begin
        state <= ext_lock ? ARB_EXT_LOCKED : ARB_EXT;
      end else begin
        state <= ARB_IDLE;
      end
    end
  end

  // Memory data arrives one cycle after the read strobe, so the ack cycle
  // forwards it directly; the held copy serves every later cycle.
  assign ext_ack           = ext_ack_q;
  assign ext_read_data     = ext_rd_ack ? mem_read_data : ext_rd_hold;
  assign cpu_mem_read_data = rd_owner ? mem_read_data : '0;
  assign owner             = state;

endmodule

// File: tb/tb_ternary_mem_arbiter.sv
// tb/tb_ternary_mem_arbiter.sv - scoreboard bench for ternary_mem_arbiter
module tb_ternary_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_mem_read = 1'b0, cpu_mem_write = 1'b0;
  logic [17:0] cpu_mem_address = '0, cpu_mem_write_data = '0;
  logic [17:0] cpu_mem_read_data;
  logic        cpu_wait;
  logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
  logic [17:0] ext_address = '0, ext_write_data = '0;
  logic        ext_ack;
  logic [17:0] ext_read_data;
  logic [17:0] mem_address, mem_write_data;
  logic        mem_read, mem_write;
  logic [17:0] mem_read_data = '0;
  logic [1:0]  owner;

  ternary_mem_arbiter #(.WORD_SIZE(9), .MEM_ADDR_SIZE(9), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_mem_address(cpu_mem_address), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read_data(cpu_mem_read_data), .cpu_wait(cpu_wait),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_address(ext_address), .ext_write_data(ext_write_data),
    .ext_ack(ext_ack), .ext_read_data(ext_read_data),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_data(mem_read_data), .owner(owner)
  );

  always #5 clock = ~clock;

  // Memory array attached to the port (addresses kept below 32).
  logic [17:0] mem [32] = '{default: '0};
  always @(posedge clock) begin
    if (mem_write) mem[mem_address[4:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[4:0]];
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int due; logic [17:0] data; } cpu_exp_t;
  typedef struct { int due; bit we; logic [17:0] data; } ext_exp_t;
  cpu_exp_t cpu_q[$];
  ext_exp_t ext_q[$];

  // Reference model: expected memory contents, lock ownership, lost contested
  // cycles, last reported owner and last external read word.
  logic [17:0] ref_mem [32] = '{default: '0};
  bit          m_locked = 0;
  int          m_loss = 0;
  logic [1:0]  m_owner = 2'd0;
  logic [17:0] m_hold = '0;
  bit          m_cpu_win = 0, m_ext_win = 0;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_cpu(input bit rd, input bit wr, input logic [17:0] a, input logic [17:0] d);
    cpu_mem_read = rd; cpu_mem_write = wr; cpu_mem_address = a; cpu_mem_write_data = d;
  endtask

  task automatic set_ext(input bit rq, input bit we, input bit lk, input logic [17:0] a, input logic [17:0] d);
    ext_req = rq; ext_we = we; ext_lock = lk; ext_address = a; ext_write_data = d;
  endtask

  // One cycle: inputs already driven just after the falling edge.
  task automatic step();
    bit lk, creq, cwin, ewin, x_rd, x_wr;
    int lo;
    logic [17:0] x_a, x_d;
    #1;
    lk   = reset ? 1'b0 : m_locked;
    lo   = reset ? 0 : m_loss;
    creq = cpu_mem_read | cpu_mem_write;
    cwin = !lk && creq && (lo < LIMIT);
    ewin = ext_req && !cwin;
    x_rd = 0; x_wr = 0; x_a = '0; x_d = '0;
    if (cwin) begin
      x_rd = cpu_mem_read && !cpu_mem_write; x_wr = cpu_mem_write;
      x_a = cpu_mem_address; x_d = cpu_mem_write_data;
    end else if (ewin) begin
      x_rd = !ext_we; x_wr = ext_we; x_a = ext_address; x_d = ext_write_data;
    end
    chk("cpu_wait", 32'(cpu_wait), 32'(creq && !cwin));
    chk("mem_read", 32'(mem_read), 32'(x_rd));
    chk("mem_write", 32'(mem_write), 32'(x_wr));
    chk("mem_address", 32'(mem_address), 32'(x_a));
    chk("mem_write_data", 32'(mem_write_data), 32'(x_d));
    chk("owner", 32'(owner), 32'(m_owner));
    if (!reset) begin
      if (cwin && x_rd) cpu_q.push_back('{cyc + 1, ref_mem[cpu_mem_address[4:0]]});
      if (ewin) ext_q.push_back('{cyc + 1, ext_we, ref_mem[ext_address[4:0]]});
    end
    if (x_wr) ref_mem[x_a[4:0]] = x_d;
    if (reset) begin
      m_locked = 0; m_loss = 0; m_owner = 2'd0; m_hold = '0;
    end else begin
      m_owner  = cwin ? 2'd1 : (ewin ? (ext_lock ? 2'd3 : 2'd2) : 2'd0);
      m_locked = ewin && ext_lock;
      if (ewin || !ext_req) m_loss = 0;
      else if (cwin) m_loss = (m_loss + 1 > LIMIT) ? LIMIT : m_loss + 1;
    end
    m_cpu_win = cwin;
    m_ext_win = ewin;
    @(posedge clock);
    @(negedge clock);
  endtask

  // Monitor: compares registered responses against the scoreboard queues.
  initial forever begin
    @(posedge clock);
    #2;
    if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
      chk("cpu_read_data", 32'(cpu_mem_read_data), 32'(cpu_q[0].data));
      void'(cpu_q.pop_front());
    end else begin
      chk("cpu_read_data_idle", 32'(cpu_mem_read_data), 32'd0);
    end
    if (ext_ack) begin
      if (ext_q.size() == 0 || ext_q[0].due != cyc) begin
        chk("ext_ack_unexpected", 32'(ext_ack), 32'd0);
      end else begin
        if (!ext_q[0].we) begin
          chk("ext_read_data", 32'(ext_read_data), 32'(ext_q[0].data));
          m_hold = ext_q[0].data;
        end
        void'(ext_q.pop_front());
      end
    end else begin
      chk("ext_read_data_hold", 32'(ext_read_data), 32'(m_hold));
      if (ext_q.size() > 0 && ext_q[0].due <= cyc) begin
        chk("ext_ack_missing", 32'(ext_ack), 32'd1);
        void'(ext_q.pop_front());
      end
    end
  end

  initial begin
    logic [17:0] w;
    int r;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // CPU-only store then read at address 5
    w = 18'h12a45;
    set_cpu(0, 1, 5, w); step();
    set_cpu(1, 0, 5, 0); step();
    set_cpu(0, 0, 0, 0); step();

    // external write of 1 to address 7, CPU idle
    set_ext(1, 1, 0, 7, 18'd1); step();
    set_ext(0, 0, 0, 0, 0); step(); step();

    // continuous CPU reads against a held external read
    set_cpu(1, 0, 7, 0); set_ext(1, 0, 0, 5, 0);
    repeat (12) step();

    // locked external burst of three writes while the CPU waits
    set_cpu(0, 0, 0, 0); set_ext(1, 1, 1, 10, 18'h00111); step();
    set_cpu(1, 0, 3, 0); set_ext(1, 1, 1, 11, 18'h00222); step();
    set_ext(1, 1, 0, 12, 18'h00333); step();
    set_ext(0, 0, 0, 0, 0); step();
    set_cpu(0, 0, 0, 0); step();

    // reset while an external read is granted
    set_cpu(1, 0, 3, 0); set_ext(1, 0, 0, 10, 0); repeat (3) step();
    set_cpu(0, 0, 0, 0); reset = 1'b1; step();
    reset = 1'b0; set_ext(0, 0, 0, 0, 0); step();

    // reset must also clear the starvation count
    set_cpu(1, 0, 3, 0); set_ext(1, 0, 0, 11, 0); repeat (3) step();
    reset = 1'b1; step();
    reset = 1'b0; repeat (6) step();

    // illegal read+write from the CPU: write wins
    set_ext(0, 0, 0, 0, 0); set_cpu(1, 1, 4, 18'h0beef); step();
    set_cpu(1, 0, 4, 0); step();
    set_cpu(0, 0, 0, 0); step();

    // randomized traffic honouring the hold-until-served protocol
    for (int i = 0; i < 3000; i++) begin
      if (!((cpu_mem_read || cpu_mem_write) && !m_cpu_win)) begin
        r = $urandom_range(0, 3);
        set_cpu(r == 1 || r == 3, r == 2, 18'($urandom_range(0, 31)), 18'($urandom));
      end
      if (!(ext_req && !m_ext_win)) begin
        set_ext($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                18'($urandom_range(0, 31)), 18'($urandom));
      end
      reset = ($urandom_range(0, 63) == 0);
      step();
    end

    reset = 1'b0;
    set_cpu(0, 0, 0, 0); set_ext(0, 0, 0, 0, 0);
    repeat (3) step();
    chk("ext_queue_drained", 32'(ext_q.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
